// File: rtl/iob_bitmap_scan_pkg.sv
// Shared types and sizing for the bitmap scanner.
package iob_bitmap_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_W = 32;
  localparam int IDX_W = $clog2(DEF_W);
  localparam int CNT_W = $clog2(DEF_W) + 1;

  localparam bit CTLS_TRAIL = 1'b0;
  localparam bit CTLS_LEAD  = 1'b1;

endpackage

// File: rtl/iob_ctls.sv
// Combinational trailing/leading zero counter.
// Result equals W when the input vector is all zeros.
module iob_ctls #(
  parameter int W    = 32,
  parameter bit MODE = 1'b0
) (
  input  logic [W-1:0]         i_vec,
  output logic [$clog2(W):0]   o_cnt
);

  localparam int CW = $clog2(W) + 1;

  always_comb begin
    o_cnt = CW'(W);
    if (MODE) begin
      for (int i = 0; i < W; i++)
        if (i_vec[i]) o_cnt = CW'(W - 1 - i);
    end else begin
      for (int i = W - 1; i >= 0; i--)
        if (i_vec[i]) o_cnt = CW'(i);
    end
  end

endmodule

// File: rtl/iob_bitmap_scan.sv
// Set-bit enumerator: emits each set bit index via valid/ready.
// IOB_BITMAP_SCAN_MSB_FIRST_EN selects highest-index-first order.
module iob_bitmap_scan
  import iob_bitmap_scan_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [W-1:0]         bitmap_i,
  output logic                 busy_o,
  output logic [$clog2(W)-1:0] idx_o,
  output logic                 idx_valid_o,
  input  logic                 idx_ready_i,
  output logic                 done_o,
  output logic [$clog2(W):0]   count_o
);

  localparam int IW = $clog2(W);
  localparam int CW = $clog2(W) + 1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_work;
  logic [IW-1:0]   r_idx;
  logic            r_vld;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_zc;
  logic [IW-1:0]   w_idx;
  logic            w_free;
  logic            w_empty;

`ifdef IOB_BITMAP_SCAN_MSB_FIRST_EN
  iob_ctls #(.W(W), .MODE(CTLS_LEAD)) u_ctls (
    .i_vec (r_work),
    .o_cnt (w_zc)
  );
  assign w_idx = IW'(W - 1) - w_zc[IW-1:0];
`else
  iob_ctls #(.W(W), .MODE(CTLS_TRAIL)) u_ctls (
    .i_vec (r_work),
    .o_cnt (w_zc)
  );
  assign w_idx = w_zc[IW-1:0];
`endif

  assign w_free  = !r_vld || idx_ready_i;
  assign w_empty = (r_work == '0);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (start_i) w_state_nxt = SCAN;
      SCAN: if (w_free && w_empty) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output slot refills whenever it is empty or being consumed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_work <= '0;
      r_idx  <= '0;
      r_vld  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_work <= bitmap_i;
            r_cnt  <= '0;
          end
        end
        SCAN: begin
          if (w_free) begin
            if (!w_empty) begin
              r_idx         <= w_idx;
              r_vld         <= 1'b1;
              r_work[w_idx] <= 1'b0;
              r_cnt         <= r_cnt + CW'(1);
            end else begin
              r_vld <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o      = (r_state != IDLE);
  assign done_o      = (r_state == DONE);
  assign idx_o       = r_idx;
  assign idx_valid_o = r_vld;
  assign count_o     = r_cnt;

endmodule

// File: tb/tb_iob_bitmap_scan.sv
// Directed bench for iob_bitmap_scan at W=8.
// Expected order follows IOB_BITMAP_SCAN_MSB_FIRST_EN when defined.
module tb_iob_bitmap_scan;

  localparam int W = 8;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [7:0] bitmap_i;
  logic       busy_o;
  logic [2:0] idx_o;
  logic       idx_valid_o;
  logic       idx_ready_i;
  logic       done_o;
  logic [3:0] count_o;

  int n_run  = 0;
  int n_fail = 0;

  int got[$];
  int first_c;
  int done_c;
  int done_n;
  int stall_err;

  iob_bitmap_scan #(.W(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .bitmap_i    (bitmap_i),
    .busy_o      (busy_o),
    .idx_o       (idx_o),
    .idx_valid_o (idx_valid_o),
    .idx_ready_i (idx_ready_i),
    .done_o      (done_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Starts a scan and collects handshaked indices until done_o.
  // c counts cycles: outputs seen after edge k+c.
  task automatic scan(input logic [7:0] bm, input bit toggle,
                      input bit mid_start);
    bit stalled;
    int prev;
    got.delete();
    first_c   = -1;
    done_c    = -1;
    done_n    = 0;
    stall_err = 0;
    stalled   = 1'b0;
    prev      = 0;
    start_i   = 1'b1;
    bitmap_i  = bm;
    idx_ready_i = 1'b1;
    tick();
    start_i  = 1'b0;
    bitmap_i = 8'h00;
    for (int c = 1; c <= 60; c++) begin
      tick();
      start_i = 1'b0;
      if (stalled && (!idx_valid_o || idx_o != prev[2:0]))
        stall_err++;
      if (idx_valid_o && first_c < 0) first_c = c;
      if (done_o) begin
        done_n++;
        done_c = c;
      end
      idx_ready_i = toggle ? c[0] : 1'b1;
      if (mid_start && c == 2) begin
        start_i  = 1'b1;
        bitmap_i = 8'h01;
      end
      if (idx_valid_o && idx_ready_i) got.push_back(int'(idx_o));
      stalled = idx_valid_o && !idx_ready_i;
      prev    = int'(idx_o);
      if (done_o) break;
    end
    start_i = 1'b0;
    idx_ready_i = 1'b1;
    tick();
    if (done_o) done_n++;
  endtask

  task automatic check_seq(input string tag, input int exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_idx%0d", tag, i), got[i], exp[i]);
  endtask

  initial begin
    int e_a4[$];
    int e_ff[$];
    rst_i       = 1'b1;
    start_i     = 1'b0;
    bitmap_i    = 8'h00;
    idx_ready_i = 1'b1;
`ifdef IOB_BITMAP_SCAN_MSB_FIRST_EN
    e_a4 = '{7, 5, 2};
    e_ff = '{7, 6, 5, 4, 3, 2, 1, 0};
`else
    e_a4 = '{2, 5, 7};
    e_ff = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_busy", busy_o, 0);
    check("rst_vld", idx_valid_o, 0);
    check("rst_done", done_o, 0);
    check("rst_cnt", count_o, 0);
    check("rst_idx", idx_o, 0);

    scan(8'hA4, 1'b0, 1'b0);
    check_seq("a4", e_a4);
    check("a4_first", first_c, 1);
    check("a4_done_c", done_c, 4);
    check("a4_done_n", done_n, 1);
    check("a4_cnt", count_o, 3);
    check("a4_busy_end", busy_o, 0);

    scan(8'hFF, 1'b1, 1'b0);
    check_seq("ff", e_ff);
    check("ff_stall", stall_err, 0);
    check("ff_done_c", done_c, 16);
    check("ff_done_n", done_n, 1);
    check("ff_cnt", count_o, 8);

    scan(8'h00, 1'b0, 1'b0);
    check("e_len", got.size(), 0);
    check("e_first", first_c, -1);
    check("e_done_c", done_c, 1);
    check("e_done_n", done_n, 1);
    check("e_cnt", count_o, 0);
    check("e_busy_k2", busy_o, 0);

    scan(8'hA4, 1'b0, 1'b1);
    check_seq("mid", e_a4);
    check("mid_cnt", count_o, 3);
    check("mid_done_n", done_n, 1);

    start_i  = 1'b1;
    bitmap_i = 8'hA4;
    tick();
    start_i  = 1'b0;
    tick();
    check("r_vld1", idx_valid_o, 1);
    check("r_idx1", idx_o, e_a4[0]);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("r_vld", idx_valid_o, 0);
    check("r_busy", busy_o, 0);
    check("r_cnt", count_o, 0);
    check("r_done", done_o, 0);
    tick();
    check("r_done2", done_o, 0);
    check("r_busy2", busy_o, 0);

    scan(8'h10, 1'b0, 1'b0);
    check_seq("s10", '{4});
    check("s10_cnt", count_o, 1);
    check("s10_done_n", done_n, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
